display_scan_ctrl: RTL

// - Scheduler/sequencer for the shared BCD-to-7-segment decoder on the multi-digit display.
// - Accepts a binary value via a load/ready handshake and converts it to BCD serially (double dabble, one bit per cycle).
// - Time-multiplexes the single decoder between digits: presents one BCD digit per scan slot and drives the matching active-low anode.
// - Sits between the value source and BCDtoSSeg; bcd feeds the decoder input, an drives the digit commons.

---
 rtl/display_scan_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Feeds the shared BCD-to-7-segment decoder on a multi-digit display.
// A binary value taken through a load/ready handshake is converted to BCD
// serially (double dabble, one bit per cycle) and committed atomically to
// the display registers. Independently, a refresh counter steps a scan
// index through the digits and drives the matching active-low anode.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   - a slot idx>0 whose digit and all higher digits are zero keeps
//               every anode high (digit dark); bcd still carries the value.
//   undefined - every digit lights in its slot, leading zeros shown.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for load; ready=1
// ST_SHIFT  | IN_W add-3/shift steps, then one more cycle that latches the
//           | finished accumulator into the display registers and raises done
// ST_COMMIT | done=1 for this cycle, display shows the new value; -> ST_IDLE

module display_scan_ctrl #(
    parameter int IN_W        = 6,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   num,
    input  logic              load,
    output logic              ready,
    output logic              done,
    output logic [3:0]        bcd,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W = $clog2(IN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [IN_W-1:0]   shift_q,   shift_d;
    logic [BCD_W-1:0]  accum_q,   accum_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BCD_W-1:0]  disp_q,    disp_d;
    logic              done_q,    done_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;

    logic [BCD_W-1:0]  accum_adj;
    logic [BCD_W-1:0]  accum_shl;
    logic [3:0]        bcd_c;
    logic [DIGITS-1:0] an_c;

    // Double-dabble step: correct every nibble >=5, then shift in the next MSB
    always_comb begin
        accum_adj = accum_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (accum_q[i*4 +: 4] >= 4'd5) begin
                accum_adj[i*4 +: 4] = accum_q[i*4 +: 4] + 4'd3;
            end
        end
        accum_shl = {accum_adj[BCD_W-2:0], shift_q[IN_W-1]};
    end

    // Conversion FSM: next state, datapath loads and the done pulse
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        accum_d   = accum_q;
        bit_cnt_d = bit_cnt_q;
        disp_d    = disp_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d   = num;
                    accum_d   = '0;
                    bit_cnt_d = BIT_W'(IN_W);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    accum_d   = accum_shl;
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else begin
                    // accumulator is complete; swap it in whole so the
                    // display never shows a partial conversion
                    disp_d  = accum_q;
                    done_d  = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan timing: free-running slot counter and digit index
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit select and anode drive, from registers only
    always_comb begin
        bcd_c = 4'd0;
        an_c  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                bcd_c   = disp_q[i*4 +: 4];
                an_c[i] = 1'b0;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic upper_zero;
            upper_zero = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                upper_zero = upper_zero && (disp_q[i*4 +: 4] == 4'd0);
                if (upper_zero && (idx_q == IDX_W'(i))) begin
                    an_c = '1;
                end
            end
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            accum_q   <= '0;
            bit_cnt_q <= '0;
            disp_q    <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            accum_q   <= accum_d;
            bit_cnt_q <= bit_cnt_d;
            disp_q    <= disp_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign done  = done_q;
    assign bcd   = bcd_c;
    assign an    = an_c;

endmodule
